alu_muldiv_unit: RTL and testbench
==================================

// Module: alu_muldiv_unit
// PURPOSE
//  Multi-cycle responder for the ALU's MUL/DIV operations (funct3_alu = 3'b011).
//  Type_alu = 1 selects MUL; Type_alu = 0 selects DIV.
//  The datapath/ALU issues one request per valid/ready handshake. The unit
//  iterates radix-2, one bit per clock, and returns a single result word
//  through a second valid/ready handshake.
//  It replaces the combinational '*' and '/' paths, which limit the single-cycle core's fmax.
// PARAMETERS
//  WIDTH   32   operand/result width in bits
//  CNT_W   $clog2(WIDTH)   iteration counter width (derived, not overridable)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      request present on operand1/operand2/Type_alu
//  in_ready    out  1      unit can accept a request (high only in IDLE)
//  operand1    in   WIDTH  multiplicand / dividend (unsigned)
//  operand2    in   WIDTH  multiplier / divisor (unsigned)
//  Type_alu    in   1      1 = MUL, 0 = DIV (same encoding as the ALU)
//  out_valid   out  1      result valid (high only in DONE)
//  out_ready   in   1      consumer takes the result
//  result      out  WIDTH  MUL: low WIDTH bits of the product; DIV: quotient
//  div_by_zero out  1      qualifies result; set with out_valid for DIV with operand2 == 0
// BEHAVIOUR
//  Reset:
//   - One clock; reset is asynchronous and active-low (clk, rst_n).
//   - Reset forces state = IDLE, in_ready = 1, out_valid = 0, result = 0,
//     div_by_zero = 0, and clears all internal registers.
//  States: IDLE, MUL, DIV, DONE.
//  IDLE:
//   - Accept occurs when in_valid && in_ready at a rising edge. On accept, latch
//     the operands and Type_alu, set cnt = 0, and clear the accumulator/remainder.
//   - Type_alu = 1 -> MUL.
//   - Type_alu = 0 and operand2 != 0 -> DIV.
//   - Type_alu = 0 and operand2 == 0 -> DONE directly, with result = all ones
//     and div_by_zero = 1 (RISC-V convention; latency 1).
//  MUL (shift-add, LSB first):
//   - Each cycle: if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1.
//   - Arithmetic is modulo 2^WIDTH; no overflow flag.
//  DIV (restoring):
//   - Each cycle: rem = {rem[WIDTH-2:0], dvd[WIDTH-1]}, then dvd <<= 1.
//   - If rem >= divisor: rem -= divisor and shift 1 into the quotient;
//     otherwise shift 0 into the quotient.
//  Both MUL and DIV:
//   - cnt increments each cycle.
//   - On the cycle where cnt == WIDTH-1, load result and go to DONE.
//   - Latency is exactly WIDTH cycles from the accept edge to out_valid high
//     (32 for the default WIDTH).
//  DONE:
//   - out_valid = 1. result and div_by_zero are held stable while out_ready = 0
//     (unlimited back-pressure).
//   - When out_valid && out_ready at a rising edge, go to IDLE.
//   - in_ready stays 0 in DONE, so there is no same-edge result/request overlap;
//     the next accept is possible one cycle later.
//  General rules:
//   - While busy (MUL/DIV/DONE), in_valid and the input buses are ignored; the
//     latched copies are used.
//   - Reset mid-operation aborts immediately: no partial result, and out_valid
//     never pulses.
//   - The remainder is computed internally and not exported.
// STRUCTURE
//  Shared package alu_pkg:
//   - FUNCT3_MULDIV = 3'b011
//   - TYPE_MUL = 1'b1, TYPE_DIV = 1'b0
//   - typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} muldiv_state_t
//  Sub-module muldiv_step:
//   - Combinational single-iteration datapath (shift-add or restore-subtract,
//     selected by mode).
//   - The top level holds the FSM, the counter and the operand registers.
// TESTING
//  1 MUL: 0x3FFFFFFF * 0x00000003 -> result 0xBFFFFFFD; out_valid rises exactly
//    32 cycles after the accept edge.
//  2 DIV: 0x3FFFFFFF / 0x00000003 -> result 0x15555555, div_by_zero = 0,
//    latency 32 cycles.
//  3 DIV by zero: 0x00001234 / 0 -> result 0xFFFFFFFF, div_by_zero = 1, out_valid
//    on the cycle after accept.
//  4 Back-pressure: MUL 7 * 6 with out_ready = 0 for 10 cycles -> result 0x0000002A
//    held and out_valid held high; in_ready = 0 throughout. Raising out_ready
//    returns the unit to IDLE with in_ready = 1 on the next cycle.
//  5 Busy ignore: a second request (0xFFFFFFFF * 0xFFFFFFFF) is driven while a
//    DIV 100 / 7 is busy -> result 0x0000000E; the second request is accepted
//    only after the handshake and yields 0x00000001.
//  6 Reset: assert rst_n = 0 asynchronously at cycle 15 of a MUL -> all outputs
//    return to reset values immediately and out_valid stays 0. A fresh MUL 2 * 3
//    after release yields 0x00000006.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the multi-cycle MUL/DIV responder.
// Holds the funct3/type encodings and the responder's state type.
package alu_pkg;

  localparam logic [2:0] FUNCT3_MULDIV = 3'b011;
  localparam logic       TYPE_MUL      = 1'b1;
  localparam logic       TYPE_DIV      = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// In DIV mode the quotient bits are shifted into the low end of the dividend register.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             mode_mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] rem_ext;
  logic           q_bit;

  // The shifted remainder keeps its carry bit so divisors above 2^(WIDTH-1) divide correctly.
  always_comb begin
    a_nxt   = a;
    b_nxt   = b;
    acc_nxt = acc;
    rem_ext = {(WIDTH+1){1'b0}};
    q_bit   = 1'b0;
    if (mode_mul) begin
      acc_nxt = acc + (b[0] ? a : {WIDTH{1'b0}});
      a_nxt   = {a[WIDTH-2:0], 1'b0};
      b_nxt   = {1'b0, b[WIDTH-1:1]};
    end else begin
      rem_ext = {acc, a[WIDTH-1]};
      if (rem_ext >= {1'b0, b}) begin
        acc_nxt = rem_ext[WIDTH-1:0] - b;
        q_bit   = 1'b1;
      end else begin
        acc_nxt = rem_ext[WIDTH-1:0];
        q_bit   = 1'b0;
      end
      a_nxt = {a[WIDTH-2:0], q_bit};
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// Multi-cycle unsigned MUL/DIV responder with valid/ready request and result handshakes.
// Holds the FSM, iteration counter and operand registers; the iteration datapath lives in muldiv_step.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             Type_alu,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] a_step, b_step, acc_step;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_mul (state_q == MUL),
    .a        (a_q),
    .b        (b_q),
    .acc      (acc_q),
    .a_nxt    (a_step),
    .b_nxt    (b_step),
    .acc_nxt  (acc_step)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = operand1;
          b_d        = operand2;
          acc_d      = {WIDTH{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          in_ready_d = 1'b0;
          if (Type_alu == TYPE_MUL) begin
            state_d = MUL;
          end else if (operand2 == {WIDTH{1'b0}}) begin
            state_d     = DONE;
            result_d    = {WIDTH{1'b1}};
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d = DIV;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL, DIV: begin
        a_d   = a_step;
        b_d   = b_step;
        acc_d = acc_step;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          result_d    = (state_q == MUL) ? acc_step : a_step;
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      result_q    <= {WIDTH{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: directed scenarios plus randomized
// operations checked against plain-arithmetic expectations.
module tb_alu_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] operand1 = '0;
  logic [W-1:0] operand2 = '0;
  logic         Type_alu = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operand1    (operand1),
    .operand2    (operand2),
    .Type_alu    (Type_alu),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  function automatic logic [W-1:0] model_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic typ);
    logic [63:0] p;
    if (typ) begin
      p = 64'(a) * 64'(b);
      return p[W-1:0];
    end
    if (b == 0) return {W{1'b1}};
    return a / b;
  endfunction

  // Waits (bounded) for in_ready, presents a request and completes the accept edge.
  task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic typ, output bit ok);
    int n = 0;
    ok = 1'b1;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready !== 1'b1) ok = 1'b0;
    operand1 = a; operand2 = b; Type_alu = typ; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts clock edges until out_valid, -1 if it never rises.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); #1; lat++;
      if (out_valid === 1'b1) return;
    end
    lat = -1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic typ);
    bit ok;
    int lat;
    logic [W-1:0] exp_r;
    int exp_lat;
    exp_r = model_result(a, b, typ);
    exp_lat = (!typ && b == 0) ? 1 : W;
    start_req(a, b, typ, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s accept: in_ready never high", name); end
    wait_valid(lat);
    checks++;
    if (lat !== exp_lat) begin failures++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat); end
    checks++;
    if (result !== exp_r) begin failures++; $display("FAIL %s result: got %h expected %h (a=%h b=%h mul=%0d)", name, result, exp_r, a, b, typ); end
    checks++;
    if (div_by_zero !== (!typ && b == 0)) begin failures++; $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, (!typ && b == 0)); end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL %s release: in_ready=%b out_valid=%b expected 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || div_by_zero !== 1'b0) begin
      failures++; $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h dbz=%b expected 1/0/0/0", in_ready, out_valid, result, div_by_zero);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op("mul_big", 32'h3FFF_FFFF, 32'h0000_0003, 1'b1);
    checks++;
    if (result !== 32'hBFFF_FFFD) begin failures++; $display("FAIL mul_big_const: got %h expected bffffffd", result); end
    run_op("div_big", 32'h3FFF_FFFF, 32'h0000_0003, 1'b0);
    checks++;
    if (result !== 32'h1555_5555) begin failures++; $display("FAIL div_big_const: got %h expected 15555555", result); end
    run_op("div_zero", 32'h0000_1234, 32'h0000_0000, 1'b0);
    run_op("div_huge_divisor", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_op("mul_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    start_req(32'd7, 32'd6, 1'b1, ok);
    wait_valid(lat);
    checks++;
    if (lat !== W) begin failures++; $display("FAIL bp_latency: got %0d expected %0d", lat, W); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h2A || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold cycle %0d: out_valid=%b result=%h in_ready=%b expected 1/0000002a/0", i, out_valid, result, in_ready);
      end
      @(posedge clk); #1;
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    int lat;
    start_req(32'd100, 32'd7, 1'b0, ok);
    operand1 = 32'hFFFF_FFFF; operand2 = 32'hFFFF_FFFF; Type_alu = 1'b1; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL busy_in_ready: got %b expected 0", in_ready); end
    wait_valid(lat);
    checks++;
    if (lat !== W || result !== 32'h0000_000E || div_by_zero !== 1'b0) begin
      failures++; $display("FAIL busy_first: lat=%0d result=%h dbz=%b expected %0d/0000000e/0", lat, result, div_by_zero, W);
    end
    consume();
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if (lat !== W || result !== 32'h0000_0001) begin
      failures++; $display("FAIL busy_second: lat=%0d result=%h expected %0d/00000001", lat, result, W);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_req(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, ok);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || div_by_zero !== 1'b0) begin
      failures++; $display("FAIL mid_reset_state: in_ready=%b out_valid=%b result=%h dbz=%b expected 1/0/0/0", in_ready, out_valid, result, div_by_zero);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_no_pulse cycle %0d: out_valid=%b expected 0", i, out_valid); end
    end
    run_op("post_reset_mul", 32'd2, 32'd3, 1'b1);
    checks++;
    if (result !== 32'h6) begin failures++; $display("FAIL post_reset_const: got %h expected 00000006", result); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic typ;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 300));
      typ = 1'($urandom_range(0, 1));
      run_op("random", a, b, typ);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
